// File: rtl/neokeon_key_sched.sv
`default_nettype none
//============================================================================
// Module   : neokeon_key_sched
// Purpose  : Key and round-constant schedule unit for the Neokeon core.
//            Holds the 128-bit working key written over the Ext interface,
//            generates the 8-bit Neokeon round-constant sequence (forward
//            for encryption, reverse for decryption) and tracks the round
//            index under a start/step handshake from the round controller.
// Ports    :
//   inClk        in   1                 clock, rising edge
//   inRst        in   1                 synchronous active-high reset
//   inExtWr      in   1                 Ext key write strobe
//   inExtData    in   KEY_W             key to load
//   inMode       in   1                 0 = encrypt, 1 = decrypt (on start)
//   inStart      in   1                 start a schedule run
//   inStep       in   1                 advance to the next round
//   outKey       out  KEY_W             stored key
//   outKeyValid  out  1                 key loaded since reset
//   outRC        out  RC_W              current round constant (zero-ext)
//   outRound     out  clog2(ROUNDS+1)   current round index
//   outBusy      out  1                 run in progress
//   outLast      out  1                 index is the output transformation
//   outDone      out  1                 one-cycle pulse at end of run
// Revision : 1.0 - initial release
//============================================================================
module neokeon_key_sched #(
    parameter int         ROUNDS  = 16,
    parameter int         KEY_W   = 128,
    parameter int         RC_W    = 32,
    parameter logic [7:0] RC_INIT = 8'h80,
    parameter logic [7:0] RC_POLY = 8'h1B
) (
    input  logic                           inClk,
    input  logic                           inRst,
    input  logic                           inExtWr,
    input  logic [KEY_W-1:0]               inExtData,
    input  logic                           inMode,
    input  logic                           inStart,
    input  logic                           inStep,
    output logic [KEY_W-1:0]               outKey,
    output logic                           outKeyValid,
    output logic [RC_W-1:0]                outRC,
    output logic [$clog2(ROUNDS+1)-1:0]    outRound,
    output logic                           outBusy,
    output logic                           outLast,
    output logic                           outDone
);

    localparam int RW = $clog2(ROUNDS + 1);

    //------------------------------------------------------------------------
    // GF(2^8) doubling and its inverse. The inverse relies on RC_POLY having
    // bit 0 set: a doubled value with the reduction applied is always odd,
    // so bit 0 tells whether the top bit had been shifted out.
    //------------------------------------------------------------------------
    function automatic logic [7:0] f_rc_fwd(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? RC_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] f_rc_bwd(input logic [7:0] y);
        logic [7:0] t;
        t = y ^ RC_POLY;
        return y[0] ? ({1'b0, t[7:1]} | 8'h80) : {1'b0, y[7:1]};
    endfunction

    // Decryption starts where encryption ends: RC_INIT doubled ROUNDS times.
    function automatic logic [7:0] f_rc_dec_init();
        logic [7:0] v;
        v = RC_INIT;
        for (int i = 0; i < ROUNDS; i++) begin
            v = f_rc_fwd(v);
        end
        return v;
    endfunction

    localparam logic [7:0]    c_rc_dec_init = f_rc_dec_init();
    localparam logic [RW-1:0] c_last_round  = RW'(ROUNDS);

    //------------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    //------------------------------------------------------------------------
    generate
        if (ROUNDS < 1 || ROUNDS > 255) begin : g_bad_rounds
            $error("neokeon_key_sched: ROUNDS must be in 1..255");
        end
        if (RC_W < 8) begin : g_bad_rc_w
            $error("neokeon_key_sched: RC_W must be at least 8");
        end
        if (RC_POLY[0] != 1'b1) begin : g_bad_poly
            $error("neokeon_key_sched: RC_POLY bit 0 must be set for the inverse step");
        end
    endgenerate

    //------------------------------------------------------------------------
    // State
    //------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [KEY_W-1:0]   r_key;
    logic               r_key_valid;
    logic [7:0]         r_rc;
    logic [RW-1:0]      r_round;
    logic               r_mode;      // 1 = decrypt, latched on accepted start
    logic               r_busy;
    logic               r_done;

    logic [7:0]         w_rc_fwd;
    logic [7:0]         w_rc_bwd;
    logic               w_at_last;

    assign w_rc_fwd  = f_rc_fwd(r_rc);
    assign w_rc_bwd  = f_rc_bwd(r_rc);
    assign w_at_last = (r_round == c_last_round);

    //------------------------------------------------------------------------
    // Schedule FSM. Busy and done are registered alongside the state so the
    // controller sees glitch-free flags.
    //------------------------------------------------------------------------
    always_ff @(posedge inClk) begin
        if (inRst) begin
            r_state     <= ST_IDLE;
            r_key       <= '0;
            r_key_valid <= 1'b0;
            r_rc        <= RC_INIT;
            r_round     <= '0;
            r_mode      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // A key write wins over a start in the same cycle.
                    if (inExtWr) begin
                        r_key       <= inExtData;
                        r_key_valid <= 1'b1;
                        r_rc        <= RC_INIT;
                    end else if (inStart && r_key_valid) begin
                        r_mode  <= inMode;
                        r_round <= '0;
                        r_rc    <= inMode ? c_rc_dec_init : RC_INIT;
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                    end
                end

                ST_RUN: begin
                    // Key writes and starts are ignored: the key is frozen.
                    if (inStep) begin
                        if (!w_at_last) begin
                            r_round <= r_round + RW'(1);
                            r_rc    <= r_mode ? w_rc_bwd : w_rc_fwd;
                        end else begin
                            // Final step: RC and round hold their values.
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    // Single cycle; all inputs ignored.
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    //------------------------------------------------------------------------
    // Outputs
    //------------------------------------------------------------------------
    assign outKey      = r_key;
    assign outKeyValid = r_key_valid;
    assign outRound    = r_round;
    assign outBusy     = r_busy;
    assign outDone     = r_done;
    assign outLast     = (r_state == ST_RUN) && w_at_last;

    generate
        if (RC_W > 8) begin : g_rc_ext
            assign outRC = {{(RC_W - 8){1'b0}}, r_rc};
        end else begin : g_rc_direct
            assign outRC = r_rc;
        end
    endgenerate

endmodule
`default_nettype wire

// File: doc/neokeon_key_sched.md
Name: neokeon_key_sched

Overview:
- Key-and-round-constant schedule unit for the Neokeon core. Generalises the fixed key/RC holding register.
- Stores the 128-bit working key loaded over the Ext interface.
- Generates the Neokeon round-constant sequence internally, forward for encryption and reverse for decryption.
- Tracks the round index under a start/step handshake from the round datapath controller.

Parameters:
- ROUNDS, 16, number of rounds before the output transformation; legal range 1..255.
- KEY_W, 128, key width.
- RC_W, 32, width of outRC; the 8-bit constant is zero-extended.
- RC_INIT, 8'h80, first encryption constant.
- RC_POLY, 8'h1B, reduction term of the GF(2^8) doubling step.

Ports:
- inClk, in, 1, clock; rising edge.
- inRst, in, 1, reset; synchronous, active-high.
- inExtWr, in, 1, Ext key write strobe.
- inExtData, in, KEY_W, key to load.
- inMode, in, 1, direction: 0 = encrypt, 1 = decrypt; sampled on the accepted start.
- inStart, in, 1, start a schedule run.
- inStep, in, 1, advance to the next round.
- outKey, out, KEY_W, stored key.
- outKeyValid, out, 1, a key has been loaded since reset.
- outRC, out, RC_W, current round constant.
- outRound, out, clog2(ROUNDS+1), current round index.
- outBusy, out, 1, run in progress.
- outLast, out, 1, current index is the output transformation (round == ROUNDS).
- outDone, out, 1, one-cycle pulse at end of run.

Behaviour:
- Reset (inRst=1 at a clock edge): key=0, outKeyValid=0, RC=RC_INIT, round=0, state=IDLE, outBusy=0, outLast=0, outDone=0. Reset overrides all other inputs.
- Forward step F(x) = (x<<1)[7:0] ^ (x[7] ? RC_POLY : 0).
- Inverse step B(y) = y[0] ? (((y ^ RC_POLY)>>1) | 8'h80) : (y>>1).
- RC_DEC_INIT is F applied ROUNDS times to RC_INIT, computed at elaboration by a constant function. Default value: 8'hD4.
- State IDLE:
  - inExtWr=1: key <= inExtData; outKeyValid <= 1; RC <= RC_INIT. inStart is ignored in the same cycle (write has priority).
  - else inStart=1 and outKeyValid=1: mode latched; round <= 0; RC <= (inMode ? RC_DEC_INIT : RC_INIT); go to RUN.
  - inStart with outKeyValid=0 is ignored; remain IDLE.
  - inStep is ignored.
- State RUN:
  - outBusy=1.
  - inStep=1 and round<ROUNDS: round <= round+1; RC <= (enc ? F(RC) : B(RC)).
  - inStep=1 and round==ROUNDS: go to DONE; RC and round hold.
  - inExtWr is ignored; the key is frozen during a run.
  - inStart is ignored.
- State DONE:
  - Lasts exactly one cycle: outDone=1, outBusy=0; then IDLE.
  - Inputs are ignored in this cycle.
- outLast is combinational: (state==RUN && round==ROUNDS).
- outRC = {RC_W-8 zeros, RC}. Values in outRC and outRound are valid in the cycle after the edge that updated them.
- Latency: first constant visible 1 cycle after the accepted start. Each step takes effect 1 cycle later. A run with ROUNDS+1 consecutive steps is ROUNDS+3 cycles from start to the end of outDone.
- After DONE, RC and round keep their final values until the next start or key write.
- Back-to-back: inStart asserted during DONE is ignored. It is accepted on the following IDLE cycle.
- Reset mid-run: abort to IDLE next cycle. Key is cleared and outKeyValid=0; a key reload is required.

Test Plan:
- Reset, write key 128'h0123..CDEF, start enc, 17 steps -> outRC sequence 80,1B,36,6C,D8,AB,4D,9A,2F,5E,BC,63,C6,97,35,6A,D4. outLast only on D4 (round 16). outDone pulse 1 cycle after the 17th step. outKey unchanged.
- Start dec with the same key, 17 steps -> outRC sequence D4,6A,35,97,C6,63,BC,5E,2F,9A,4D,AB,D8,6C,36,1B,80.
- inExtWr with new data at round 5 of a run -> outKey keeps the old value. After outDone, a write in IDLE updates outKey next cycle.
- inStart after reset with no key written -> outBusy stays 0, outRC=80. inStart and inExtWr in the same cycle -> key loads, no run starts.
- inRst asserted at round 7 of a dec run -> next cycle: outBusy=0, outRound=0, outRC=80, outKeyValid=0, outKey=0, no outDone.
- ROUNDS=4 build: enc sequence 80,1B,36,6C,D8. Dec starts at D8 and ends at 80. outRound width 3.
